// File: rtl/uart_tx_parity.sv
// uart_tx_parity: UART transmitter, 8 data bits LSB first, even parity, 1 stop bit.
// Frame: start(0), d0..d7, parity, stop(1). Each bit lasts CLKS_PER_BIT clocks.
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   txStart    frame request, sampled only in IDLE
//   txData     byte to send, latched when txStart is accepted
//   txFlagClr  active-low clear of txFlag, honoured only in DONE
//   tx         serial line, idle high
//   busy       high from frame acceptance until DONE is entered
//   txFlag     sticky frame-complete flag, high while in DONE
module uart_tx_parity #(
   parameter int unsigned CLKS_PER_BIT = 5208
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       txStart,
   input  logic [7:0] txData,
   input  logic       txFlagClr,
   output logic       tx,
   output logic       busy,
   output logic       txFlag
);

   localparam int unsigned BAUD_W = 16;
   localparam int unsigned BIT_W  = 3;
   localparam int unsigned DATA_W = 8;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   logic [2:0]        r_state;
   logic [BAUD_W-1:0] r_baud;
   logic [BIT_W-1:0]  r_bit;
   logic [DATA_W-1:0] r_shift;
   logic              r_parity;
   logic              r_tx;
   logic              r_busy;
   logic              r_flag;

   logic [2:0]        w_state;
   logic [BAUD_W-1:0] w_baud;
   logic [BIT_W-1:0]  w_bit;
   logic [DATA_W-1:0] w_shift;
   logic              w_parity;
   logic              w_tx;
   logic              w_busy;
   logic              w_flag;
   logic              w_tc;

   assign tx     = r_tx;
   assign busy   = r_busy;
   assign txFlag = r_flag;

   // End of the current bit period
   assign w_tc = (r_baud == BAUD_LAST);

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_baud   <= '0;
         r_bit    <= '0;
         r_shift  <= '0;
         r_parity <= 1'b0;
         r_tx     <= 1'b1;
         r_busy   <= 1'b0;
         r_flag   <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_baud   <= w_baud;
         r_bit    <= w_bit;
         r_shift  <= w_shift;
         r_parity <= w_parity;
         r_tx     <= w_tx;
         r_busy   <= w_busy;
         r_flag   <= w_flag;
      end
   end

   // Next-state and next-output logic; outputs are set one edge ahead of the bit they drive
   always_comb begin
      w_state  = r_state;
      w_baud   = r_baud;
      w_bit    = r_bit;
      w_shift  = r_shift;
      w_parity = r_parity;
      w_tx     = r_tx;
      w_busy   = r_busy;
      w_flag   = r_flag;

      case (r_state)
         S_IDLE: begin
            w_tx   = 1'b1;
            w_busy = 1'b0;
            w_flag = 1'b0;
            w_baud = '0;
            w_bit  = '0;
            if (txStart) begin
               w_shift  = txData;
               w_parity = ^txData;
               w_state  = S_START;
               w_tx     = 1'b0;
               w_busy   = 1'b1;
            end
         end

         S_START: begin
            if (w_tc) begin
               w_baud  = '0;
               w_state = S_DATA;
               w_tx    = r_shift[0];
            end else begin
               w_baud = r_baud + BAUD_W'(1);
            end
         end

         S_DATA: begin
            if (w_tc) begin
               w_baud  = '0;
               w_shift = {1'b0, r_shift[DATA_W-1:1]};
               w_bit   = r_bit + BIT_W'(1);
               if (r_bit == BIT_LAST) begin
                  w_state = S_PARITY;
                  w_tx    = r_parity;
               end else begin
                  // Next data bit is the one about to land in shift[0]
                  w_tx = r_shift[1];
               end
            end else begin
               w_baud = r_baud + BAUD_W'(1);
            end
         end

         S_PARITY: begin
            if (w_tc) begin
               w_baud  = '0;
               w_state = S_STOP;
               w_tx    = 1'b1;
            end else begin
               w_baud = r_baud + BAUD_W'(1);
            end
         end

         S_STOP: begin
            if (w_tc) begin
               w_baud  = '0;
               w_state = S_DONE;
               w_flag  = 1'b1;
               w_busy  = 1'b0;
            end else begin
               w_baud = r_baud + BAUD_W'(1);
            end
         end

         S_DONE: begin
            w_tx   = 1'b1;
            w_busy = 1'b0;
            w_flag = 1'b1;
            w_baud = '0;
            // Clear wins over a simultaneous start; the start is seen next edge in IDLE
            if (!txFlagClr) begin
               w_state = S_IDLE;
               w_flag  = 1'b0;
            end
         end

         default: begin
            w_state = S_IDLE;
            w_tx    = 1'b1;
            w_busy  = 1'b0;
            w_flag  = 1'b0;
            w_baud  = '0;
            w_bit   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_parity.sv
module tb_uart_tx_parity;

   localparam int unsigned CPB  = 4;
   localparam int unsigned CPB2 = 2;
   localparam int          FRAME_CYC  = 11 * CPB;
   localparam int          FRAME_CYC2 = 11 * CPB2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       txStart = 1'b0;
   logic [7:0] txData = 8'h00;
   logic       txFlagClr = 1'b1;
   logic       tx, busy, txFlag;

   logic       txStart2 = 1'b0;
   logic [7:0] txData2 = 8'h00;
   logic       txFlagClr2 = 1'b1;
   logic       tx2, busy2, txFlag2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   uart_tx_parity #(.CLKS_PER_BIT(CPB)) u_dut (
      .clk(clk), .rst(rst), .txStart(txStart), .txData(txData),
      .txFlagClr(txFlagClr), .tx(tx), .busy(busy), .txFlag(txFlag)
   );

   uart_tx_parity #(.CLKS_PER_BIT(CPB2)) u_dut2 (
      .clk(clk), .rst(rst), .txStart(txStart2), .txData(txData2),
      .txFlagClr(txFlagClr2), .tx(tx2), .busy(busy2), .txFlag(txFlag2)
   );

   // Expected frame, bit index = time order: [0]=start, [8:1]=data LSB first, [9]=parity, [10]=stop
   typedef struct {
      logic [7:0]  data;
      logic [10:0] frame;
      int          inject;   // cycle at which a stray txStart/txFlagClr is pulsed, -1 = none
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Send one frame on u_dut and check every cycle through DONE entry
   task automatic send_frame(input logic [7:0] data, input logic [10:0] frame,
                             input int inject, input string tag);
      @(negedge clk);
      txData  = data;
      txStart = 1'b1;
      @(posedge clk);
      for (int c = 0; c < FRAME_CYC; c++) begin
         @(negedge clk);
         if (c == 0) begin
            txStart = 1'b0;
            txData  = ~data;
         end
         if (c == inject) begin
            txStart   = 1'b1;
            txData    = 8'h3C;
            txFlagClr = 1'b0;
         end else if (c == inject + 1) begin
            txStart   = 1'b0;
            txFlagClr = 1'b1;
         end
         chk($sformatf("%s tx c%0d", tag, c), 32'(tx), 32'(frame[c / CPB]));
         chk($sformatf("%s busy/flag c%0d", tag, c), 32'({busy, txFlag}), 32'(2'b10));
      end
      txStart   = 1'b0;
      txFlagClr = 1'b1;
      @(negedge clk);
      chk($sformatf("%s done tx", tag), 32'(tx), 32'(1'b1));
      chk($sformatf("%s done busy/flag", tag), 32'({busy, txFlag}), 32'(2'b01));
   endtask

   task automatic clear_flag(input string tag);
      @(negedge clk);
      txFlagClr = 1'b0;
      @(negedge clk);
      txFlagClr = 1'b1;
      chk($sformatf("%s clr tx", tag), 32'(tx), 32'(1'b1));
      chk($sformatf("%s clr busy/flag", tag), 32'({busy, txFlag}), 32'(2'b00));
   endtask

   initial begin
      logic [10:0] f5a;
      logic [10:0] f07;
      f5a = 11'b1_0_01011010_0;
      f07 = 11'b1_1_00000111_0;

      vecs[0] = '{8'hA5, 11'b1_0_10100101_0, -1};
      vecs[1] = '{8'h07, 11'b1_1_00000111_0, -1};
      vecs[2] = '{8'h00, 11'b1_0_00000000_0, -1};
      vecs[3] = '{8'hFF, 11'b1_0_11111111_0, -1};
      vecs[4] = '{8'h01, 11'b1_1_00000001_0, -1};
      vecs[5] = '{8'h5A, 11'b1_0_01011010_0, 10};

      // Reset state
      #12;
      chk("reset tx", 32'(tx), 32'(1'b1));
      chk("reset busy/flag", 32'({busy, txFlag}), 32'(2'b00));
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle tx", 32'(tx), 32'(1'b1));
      chk("idle busy/flag", 32'({busy, txFlag}), 32'(2'b00));

      // Table-driven frames; the last one carries a stray mid-frame start and clear
      for (int i = 0; i < 6; i++) begin
         send_frame(vecs[i].data, vecs[i].frame, vecs[i].inject, $sformatf("v%0d", i));
         if (vecs[i].inject >= 0) begin
            repeat (20) begin
               @(negedge clk);
               chk("hold tx", 32'(tx), 32'(1'b1));
               chk("hold busy/flag", 32'({busy, txFlag}), 32'(2'b01));
            end
         end
         clear_flag($sformatf("v%0d", i));
         if (vecs[i].inject >= 0) begin
            repeat (5) begin
               @(negedge clk);
               chk("no 2nd frame tx", 32'(tx), 32'(1'b1));
               chk("no 2nd frame busy", 32'(busy), 32'(1'b0));
            end
         end
      end

      // Reset in the middle of data bit 3
      @(negedge clk);
      txData  = 8'h5A;
      txStart = 1'b1;
      @(posedge clk);
      for (int c = 0; c < 18; c++) begin
         @(negedge clk);
         if (c == 0) txStart = 1'b0;
         chk($sformatf("rst frame tx c%0d", c), 32'(tx), 32'(f5a[c / CPB]));
      end
      #1 rst = 1'b0;
      #1;
      chk("async rst tx", 32'(tx), 32'(1'b1));
      chk("async rst busy/flag", 32'({busy, txFlag}), 32'(2'b00));
      @(negedge clk);
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("post rst idle tx", 32'(tx), 32'(1'b1));
         chk("post rst busy/flag", 32'({busy, txFlag}), 32'(2'b00));
      end
      send_frame(8'h81, 11'b1_0_10000001_0, -1, "x81");
      clear_flag("x81");

      // Back-to-back frames, CLKS_PER_BIT=2, start and clear held
      @(negedge clk);
      txData2    = 8'h07;
      txFlagClr2 = 1'b0;
      txStart2   = 1'b1;
      @(posedge clk);
      for (int f = 0; f < 3; f++) begin
         for (int c = 0; c < FRAME_CYC2 + 2; c++) begin
            @(negedge clk);
            if (c < FRAME_CYC2) begin
               chk($sformatf("b2b f%0d tx c%0d", f, c), 32'(tx2), 32'(f07[c / CPB2]));
               chk($sformatf("b2b f%0d busy/flag c%0d", f, c), 32'({busy2, txFlag2}), 32'(2'b10));
            end else if (c == FRAME_CYC2) begin
               chk($sformatf("b2b f%0d done tx", f), 32'(tx2), 32'(1'b1));
               chk($sformatf("b2b f%0d done busy/flag", f), 32'({busy2, txFlag2}), 32'(2'b01));
            end else begin
               chk($sformatf("b2b f%0d idle tx", f), 32'(tx2), 32'(1'b1));
               chk($sformatf("b2b f%0d idle busy/flag", f), 32'({busy2, txFlag2}), 32'(2'b00));
            end
         end
      end
      txStart2   = 1'b0;
      txFlagClr2 = 1'b1;
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_parity.md
Name: uart_tx_parity

Overview:
- Transmit half of the full-duplex UART.
- Serialises one 8-bit byte per frame, LSB first. Frame: 1 start bit, 8 data bits, 1 even-parity bit, 1 stop bit.
- The frame format is identical to the one the receive path expects.
- The byte source is a switch/register bank. Completion is reported via a sticky flag that stays set until explicitly cleared, the same flag/clear handshake the receive path uses.

Parameters:
- CLKS_PER_BIT, 5208: clk cycles per bit period (50 MHz / 9600 baud). Legal range 2..65535.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- txStart  input  1  frame request, active-high; sampled only in IDLE
- txData  input  8  byte to send; latched on the edge that accepts txStart
- txFlagClr  input  1  flag clear, active-low (button style); 0 = clear txFlag
- tx  output  1  serial line; idle high
- busy  output  1  high from frame acceptance until DONE is entered
- txFlag  output  1  frame-complete flag; high in DONE

Behaviour:
- All outputs are registered and change on the same clk edge as the state register.
- Reset (rst=0, asynchronous, effective immediately):
  - state=IDLE, tx=1, busy=0, txFlag=0.
  - Baud counter, bit counter, shift register and parity register all cleared.
- Internal registers:
  - Baud counter: 16-bit, counts 0..CLKS_PER_BIT-1. Its terminal count ends the current bit period.
  - Bit counter: 3-bit, counts 0..7.
  - Shift register: 8-bit.
  - Parity register: 1-bit, equal to ^txData (XOR of latched bits). The total number of ones across the data bits plus the parity bit is therefore even.
- State machine:
  - IDLE:
    - Outputs: tx=1, busy=0, txFlag=0.
    - If txStart=1 at an edge: latch txData into the shift register, compute parity, clear both counters, go to START.
    - On that same edge tx<=0 and busy<=1.
  - START:
    - tx=0 for CLKS_PER_BIT cycles.
    - At terminal count, go to DATA with tx<=shift[0].
  - DATA:
    - tx=shift[0]. At each terminal count, shift right and increment the bit counter.
    - After the bit period with bit counter=7, go to PARITY, tx<=parity.
    - Exactly 8 bit periods are spent in DATA.
  - PARITY:
    - tx=parity for one bit period, then go to STOP, tx<=1.
  - STOP:
    - tx=1 for one bit period.
    - At terminal count, go to DONE with txFlag<=1 and busy<=0.
  - DONE:
    - Outputs: tx=1, txFlag=1, busy=0.
    - If txFlagClr=0 at an edge: go to IDLE, txFlag<=0.
    - Otherwise remain in DONE.
  - Unreachable encodings: go to IDLE with reset output values.
- Frame timing:
  - From the edge that accepts txStart to the edge that enters DONE is exactly 11*CLKS_PER_BIT cycles.
  - tx is low for the first CLKS_PER_BIT of those cycles.
- Boundary conditions:
  - txStart while not in IDLE: ignored, no effect on the current frame.
  - txData changes after acceptance: ignored; the latched copy is sent.
  - txStart held high continuously: a new frame begins on the first edge after DONE exits to IDLE. The line stays high for at least one cycle in IDLE.
  - txFlagClr=0 while not in DONE: ignored.
  - txFlagClr=0 and txStart=1 simultaneously while in DONE: go to IDLE only; the start is taken on the next edge.
  - Reset mid-frame: tx returns to 1 asynchronously and the frame is aborted. No txFlag is raised.
  - CLKS_PER_BIT=2: must still meet the exact timing above.
- Counter arithmetic: the baud counter wraps to 0 at terminal count, with no cumulative drift. It is held at 0 in IDLE and DONE.

Test Plan:
- CLKS_PER_BIT=4, txData=0xA5, txStart pulse → tx sequence per bit: 0,1,0,1,0,0,1,0,1,0(parity),1. Each bit is held exactly 4 cycles. txFlag rises 44 cycles after acceptance and busy falls on the same edge.
- txData=0x07 → data bits 1,1,1,0,0,0,0,0, parity=1. txData=0x00 → parity=0. txData=0xFF → parity=0.
- txStart pulsed mid-frame with txData=0x3C while sending 0x5A → the 0x5A frame is unaltered and no second frame is sent.
- Hold txFlagClr=1 after DONE for 20 cycles → txFlag stays 1 and tx stays 1. Drive txFlagClr=0 for 1 cycle → txFlag=0, state IDLE.
- Assert rst=0 during DATA bit 3 → tx=1, busy=0, txFlag=0 immediately. After rst=1, txStart with 0x81 → a clean full frame.
- txStart held high with txFlagClr held low, CLKS_PER_BIT=2 → back-to-back frames 22 cycles long, each separated by exactly one idle-high cycle plus one DONE cycle.
